// File: rtl/fpga_clk_rst_seq_pkg.sv
// Shared FPGA target definitions: sequencer state encoding, the default SoC clock
// divider (also used as the clock divider's power-on value) and small helpers.
package fpga_clk_rst_seq_pkg;

  localparam int unsigned FpgaDefaultDiv = 4;

  typedef enum logic [2:0] {
    WAIT_CALIB,
    PROG,
    SETTLE,
    RUN,
    DRAIN,
    HOLD,
    ERROR
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Dividing by 0 or 1 would run the SoC at or above the DRAM auxiliary clock.
  function automatic logic div_is_legal(input int unsigned div);
    return div >= 32'd2;
  endfunction

endpackage

// File: rtl/fpga_seq_cnt.sv
// Loadable saturating down-counter with a done flag, shared by the sequencer's timed states.
// The owner loads it during reset, so it needs no reset of its own.
module fpga_seq_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [Width-1:0] count;

  // Load wins over counting; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - Width'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/fpga_clk_rst_seq.sv
// FPGA clock/reset bring-up and run-time divider reconfiguration sequencer.
// Optional calibration watchdog and ERROR state: define FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN.
module fpga_clk_rst_seq
  import fpga_clk_rst_seq_pkg::*;
#(
  parameter int unsigned DivWidth     = 4,
  parameter int unsigned DefaultDiv   = FpgaDefaultDiv,
  parameter int unsigned SettleCycles = 64,
  parameter int unsigned HoldCycles   = 16
`ifdef FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN
  ,
  parameter int unsigned CalibTimeout = 1048576
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                calib_done_i,
  output logic [DivWidth-1:0] div_value_o,
  output logic                div_valid_o,
  input  logic                div_ready_i,
  output logic                drain_req_o,
  input  logic                drain_ack_i,
  output logic                soc_rst_no,
  input  logic                reconf_req_i,
  input  logic [DivWidth-1:0] reconf_div_i,
  output logic                reconf_ack_o,
  output logic                running_o,
  output logic                error_o
);

`ifdef FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN
  localparam int unsigned CntLimit = max_u(max_u(SettleCycles, HoldCycles), CalibTimeout);
`else
  localparam int unsigned CntLimit = max_u(SettleCycles, HoldCycles);
`endif
  localparam int unsigned CntWidth = $clog2(CntLimit) + 1;

  seq_state_e          state;
  seq_state_e          next_state;
  seq_state_e          load_target;
  logic [DivWidth-1:0] pending_div;
  logic [DivWidth-1:0] div_value_q;
  logic                div_valid_q;
  logic                drain_req_q;
  logic                soc_rst_n_q;
  logic                running_q;
  logic                reconf_ack_q;
  logic                error_q;
  logic                reconf_flag;
  logic                hold_to_calib;
  logic                calib_lost;
  logic                reconf_take;
  logic                illegal_req;
  logic                cnt_load;
  logic                cnt_en;
  logic                cnt_done;
  logic [CntWidth-1:0] cnt_value;
  logic                live_now;
  logic                live_next;

  fpga_seq_cnt #(
    .Width(CntWidth)
  ) u_cnt (
    .clk       (clk_i),
    .load      (cnt_load),
    .load_value(cnt_value),
    .enable    (cnt_en),
    .done      (cnt_done)
  );

  // Calibration loss outranks a reconfiguration request because DRAM is already gone.
  always_comb begin
    next_state  = state;
    calib_lost  = 1'b0;
    reconf_take = 1'b0;
    illegal_req = 1'b0;
    case (state)
      WAIT_CALIB: begin
        if (calib_done_i) next_state = PROG;
`ifdef FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN
        else if (cnt_done) next_state = ERROR;
`endif
      end
      PROG: begin
        if (div_ready_i) next_state = SETTLE;
      end
      SETTLE: begin
        if (cnt_done) next_state = RUN;
      end
      RUN: begin
        if (!calib_done_i) begin
          next_state = HOLD;
          calib_lost = 1'b1;
        end else if (reconf_req_i) begin
          if (div_is_legal(32'(reconf_div_i))) begin
            next_state  = DRAIN;
            reconf_take = 1'b1;
          end else begin
            illegal_req = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_ack_i) next_state = HOLD;
      end
      HOLD: begin
        if (cnt_done) next_state = hold_to_calib ? WAIT_CALIB : PROG;
      end
`ifdef FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN
      ERROR: begin
        next_state = ERROR;
      end
`endif
      default: begin
        next_state = WAIT_CALIB;
      end
    endcase
  end

  // The counter is reloaded on every state change with the length of the state being entered.
  always_comb begin
    load_target = rst_i ? WAIT_CALIB : next_state;
    cnt_load    = rst_i || (next_state != state);
    cnt_value   = '0;
    case (load_target)
      SETTLE:     cnt_value = CntWidth'(SettleCycles - 1);
      HOLD:       cnt_value = CntWidth'(HoldCycles - 1);
`ifdef FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN
      WAIT_CALIB: cnt_value = CntWidth'(CalibTimeout - 1);
`endif
      default:    cnt_value = '0;
    endcase
    cnt_en = (state == SETTLE) || (state == HOLD);
`ifdef FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN
    cnt_en = cnt_en || (state == WAIT_CALIB);
`endif
    live_now  = (state == RUN) || (state == DRAIN);
    live_next = (next_state == RUN) || (next_state == DRAIN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= WAIT_CALIB;
      pending_div   <= DivWidth'(DefaultDiv);
      div_value_q   <= DivWidth'(DefaultDiv);
      div_valid_q   <= 1'b0;
      drain_req_q   <= 1'b0;
      soc_rst_n_q   <= 1'b0;
      running_q     <= 1'b0;
      reconf_ack_q  <= 1'b0;
      error_q       <= 1'b0;
      reconf_flag   <= 1'b0;
      hold_to_calib <= 1'b0;
    end else begin
      state        <= next_state;
      div_valid_q  <= (next_state == PROG);
      drain_req_q  <= (next_state == DRAIN);
      soc_rst_n_q  <= live_now && live_next;
      running_q    <= (state == RUN) && (next_state == RUN);
      reconf_ack_q <= reconf_flag && (state == RUN) && (next_state == RUN);
      // The divider value is frozen for the whole PROG visit so it cannot move under valid.
      if ((next_state == PROG) && (state != PROG)) begin
        div_value_q <= pending_div;
      end
      // Only legal requests update the pending divider, so a calibration-loss restart
      // always reprograms the last divider that actually ran.
      if (reconf_take) begin
        pending_div <= reconf_div_i;
      end
      if (reconf_take) begin
        reconf_flag <= 1'b1;
      end else if (state == RUN) begin
        reconf_flag <= 1'b0;
      end
      if (calib_lost) begin
        hold_to_calib <= 1'b1;
      end else if ((state == HOLD) && (next_state != HOLD)) begin
        hold_to_calib <= 1'b0;
      end
      if (illegal_req) begin
        error_q <= 1'b1;
      end
`ifdef FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN
      if ((state == WAIT_CALIB) && (next_state == ERROR)) begin
        error_q <= 1'b1;
      end
`endif
    end
  end

  assign div_value_o  = div_value_q;
  assign div_valid_o  = div_valid_q;
  assign drain_req_o  = drain_req_q;
  assign soc_rst_no   = soc_rst_n_q;
  assign running_o    = running_q;
  assign reconf_ack_o = reconf_ack_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_fpga_clk_rst_seq.sv
// Scoreboard bench for fpga_clk_rst_seq: expected sequencer events are queued by the
// stimulus, a negedge monitor turns DUT activity into events and compares them in order.
module tb_fpga_clk_rst_seq;

  localparam int DivWidth     = 4;
  localparam int DefaultDiv   = 4;
  localparam int SettleCycles = 64;
  localparam int HoldCycles   = 16;
`ifdef FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN
  localparam int CalibTimeout = 1000;
`endif

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                calib_done_i = 1'b0;
  logic [DivWidth-1:0] div_value_o;
  logic                div_valid_o;
  logic                div_ready_i = 1'b1;
  logic                drain_req_o;
  logic                drain_ack_i = 1'b0;
  logic                soc_rst_no;
  logic                reconf_req_i = 1'b0;
  logic [DivWidth-1:0] reconf_div_i = '0;
  logic                reconf_ack_o;
  logic                running_o;
  logic                error_o;

  typedef enum int {EV_HS, EV_RUN, EV_ACK, EV_DRAIN, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       value;
  } ev_t;

  ev_t expq[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  currentDiv = DefaultDiv;

  always #5 clk = ~clk;

  fpga_clk_rst_seq #(
    .DivWidth    (DivWidth),
    .DefaultDiv  (DefaultDiv),
    .SettleCycles(SettleCycles),
    .HoldCycles  (HoldCycles)
`ifdef FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN
    ,
    .CalibTimeout(CalibTimeout)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .calib_done_i(calib_done_i),
    .div_value_o (div_value_o),
    .div_valid_o (div_valid_o),
    .div_ready_i (div_ready_i),
    .drain_req_o (drain_req_o),
    .drain_ack_i (drain_ack_i),
    .soc_rst_no  (soc_rst_no),
    .reconf_req_i(reconf_req_i),
    .reconf_div_i(reconf_div_i),
    .reconf_ack_o(reconf_ack_o),
    .running_o   (running_o),
    .error_o     (error_o)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectEvent(input ev_kind_e kind, input int value);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    expq.push_back(e);
  endtask

  task automatic scoreEvent(input ev_kind_e kind, input int value);
    ev_t e;
    vectors++;
    if (expq.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL unexpected_event: got %s/%0d, expected none (cycle %0d)", kind.name(), value, cyc);
    end else begin
      e = expq.pop_front();
      if ((e.kind != kind) || (e.value != value)) begin
        miscompares++;
        $display("[TB] FAIL event_order: got %s/%0d, expected %s/%0d (cycle %0d)",
                 kind.name(), value, e.kind.name(), e.value, cyc);
      end
    end
  endtask

  // Monitor: samples on the negedge, converts DUT activity into events for the scoreboard.
  logic                prevValid = 1'b0;
  logic                prevReady = 1'b0;
  logic                prevRst = 1'b1;
  logic                prevSocRst = 1'b0;
  logic                prevDrain = 1'b0;
  logic                prevErr = 1'b0;
  logic [DivWidth-1:0] prevValue = '0;
  int                  hsEdge = 0;
  int                  drainLen = 0;

  always @(negedge clk) begin
    cyc++;
    if (!prevRst && prevValid && !prevReady) begin
      checkOutput("valid_held_without_ready", int'(div_valid_o), 1);
      if (div_valid_o) checkOutput("value_stable_under_valid", int'(div_value_o), int'(prevValue));
    end
    if (!rst_i && div_valid_o && div_ready_i) begin
      scoreEvent(EV_HS, int'(div_value_o));
      hsEdge = cyc + 1;
    end
    if (soc_rst_no && !prevSocRst) scoreEvent(EV_RUN, cyc - hsEdge);
    if (reconf_ack_o) scoreEvent(EV_ACK, cyc - hsEdge);
    if (drain_req_o) begin
      drainLen++;
    end else if (prevDrain) begin
      if (!prevRst) scoreEvent(EV_DRAIN, drainLen);
      drainLen = 0;
    end
    if (error_o && !prevErr) scoreEvent(EV_ERR, 0);
    prevValid  = div_valid_o;
    prevReady  = div_ready_i;
    prevRst    = rst_i;
    prevSocRst = soc_rst_no;
    prevDrain  = drain_req_o;
    prevErr    = error_o;
    prevValue  = div_value_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reconfiguration request pulse.
  task automatic applyStimulus(input int div);
    reconf_req_i = 1'b1;
    reconf_div_i = DivWidth'(div);
    tick();
    reconf_req_i = 1'b0;
  endtask

  task automatic waitRunning(input string name);
    int n = 0;
    while (!running_o && n < 400) begin
      tick();
      n++;
    end
    checkOutput(name, int'(running_o), 1);
    checkOutput({name, "_soc_rst"}, int'(soc_rst_no), 1);
  endtask

  // Model: after calibration the divider is handshaken once, then the SoC leaves reset
  // SettleCycles+1 cycles after the handshake edge; bring-up never acknowledges.
  task automatic bringUp(input int calibDelay, input int stall, input int expDiv);
    int n = 0;
    div_ready_i = (stall == 0);
    repeat (calibDelay) tick();
    checkOutput("wait_calib_no_valid", int'(div_valid_o), 0);
    expectEvent(EV_HS, expDiv);
    expectEvent(EV_RUN, SettleCycles + 1);
    calib_done_i = 1'b1;
    if (stall > 0) begin
      while (!div_valid_o && n < 50) begin
        tick();
        n++;
      end
      checkOutput("prog_valid_seen", int'(div_valid_o), 1);
      repeat (stall) tick();
      div_ready_i = 1'b1;
    end
    waitRunning("bringup_running");
  endtask

  // Model: drain lasts exactly the acknowledge latency, reset is held HoldCycles before
  // the new value is offered, then settle and a single acknowledge pulse.
  task automatic reconfigure(input int div, input int lat);
    int n = 0;
    expectEvent(EV_DRAIN, lat);
    expectEvent(EV_HS, div);
    expectEvent(EV_RUN, SettleCycles + 1);
    expectEvent(EV_ACK, SettleCycles + 1);
    applyStimulus(div);
    repeat (lat - 1) tick();
    drain_ack_i = 1'b1;
    tick();
    drain_ack_i = 1'b0;
    while (!div_valid_o && n < 100) begin
      tick();
      n++;
    end
    checkOutput("hold_cycles", n, HoldCycles);
    checkOutput("hold_soc_rst_low", int'(soc_rst_no), 0);
    waitRunning("reconf_running");
    currentDiv = div;
  endtask

  initial begin
    int sawDrain;
    repeat (3) tick();
    checkOutput("reset_soc_rst", int'(soc_rst_no), 0);
    checkOutput("reset_valid", int'(div_valid_o), 0);
    checkOutput("reset_div_value", int'(div_value_o), DefaultDiv);
    checkOutput("reset_drain", int'(drain_req_o), 0);
    checkOutput("reset_ack", int'(reconf_ack_o), 0);
    checkOutput("reset_running", int'(running_o), 0);
    checkOutput("reset_error", int'(error_o), 0);
    rst_i = 1'b0;

    bringUp($urandom_range(20, 100), 0, DefaultDiv);
    checkOutput("bringup_error", int'(error_o), 0);

    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(2, 10)) tick();
      reconfigure($urandom_range(2, 15), $urandom_range(1, 8));
    end

    expectEvent(EV_ERR, 0);
    applyStimulus($urandom_range(0, 1));
    repeat (3) tick();
    checkOutput("illegal_soc_rst", int'(soc_rst_no), 1);
    checkOutput("illegal_running", int'(running_o), 1);
    checkOutput("illegal_drain", int'(drain_req_o), 0);
    checkOutput("illegal_error", int'(error_o), 1);

    reconfigure(8, 5);
    checkOutput("error_sticky", int'(error_o), 1);

    calib_done_i = 1'b0;
    applyStimulus(currentDiv);
    sawDrain = 0;
    repeat (40) begin
      if (drain_req_o) sawDrain = 1;
      tick();
    end
    checkOutput("calib_loss_no_drain", sawDrain, 0);
    checkOutput("calib_loss_soc_rst", int'(soc_rst_no), 0);
    checkOutput("calib_loss_wait_calib", int'(div_valid_o), 0);
    bringUp($urandom_range(5, 30), $urandom_range(5, 10), currentDiv);

    applyStimulus($urandom_range(2, 15));
    repeat (2) tick();
    rst_i = 1'b1;
    tick();
    checkOutput("drain_reset_req", int'(drain_req_o), 0);
    checkOutput("drain_reset_soc_rst", int'(soc_rst_no), 0);
    checkOutput("drain_reset_error", int'(error_o), 0);
    checkOutput("drain_reset_div", int'(div_value_o), DefaultDiv);
    rst_i = 1'b0;
    currentDiv = DefaultDiv;
    bringUp(0, 0, DefaultDiv);

    div_ready_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (3) tick();
    checkOutput("prog_stalled_valid", int'(div_valid_o), 1);
    rst_i = 1'b1;
    tick();
    checkOutput("prog_reset_valid", int'(div_valid_o), 0);
    rst_i = 1'b0;
    bringUp(0, 0, DefaultDiv);

`ifdef FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN
    begin
      int n = 0;
      calib_done_i = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      expectEvent(EV_ERR, 0);
      while (!error_o && n < CalibTimeout + 50) begin
        tick();
        n++;
      end
      checkOutput("timeout_cycle", n, CalibTimeout);
      repeat (5) tick();
      checkOutput("timeout_soc_rst", int'(soc_rst_no), 0);
      rst_i = 1'b1;
      tick();
      checkOutput("timeout_reset_clears", int'(error_o), 0);
      rst_i = 1'b0;
    end
`endif

    repeat (10) tick();
    checkOutput("scoreboard_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("[TB] FAIL watchdog: got no end of test, expected completion (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpga_clk_rst_seq.md
Name: fpga_clk_rst_seq

Overview:
- Bring-up and reconfiguration sequencer for the FPGA target clock/reset tree.
- Sits beside the SoC clock divider and reset generator, clocked by the free-running DRAM auxiliary clock.
- Waits for DRAM calibration, programs the SoC clock divider over its valid/ready interface, waits for the clock to settle, then releases the SoC and CDC resets.
- Also supports run-time divider changes: drain the DRAM path, hold reset, reprogram, re-release.

Parameters:
- DivWidth, 4, width of the divider value.
- DefaultDiv, 4, divider programmed at bring-up (200 MHz / 4 = 50 MHz SoC clock).
- SettleCycles, 64, cycles waited after the divider handshake before reset release.
- HoldCycles, 16, minimum cycles SoC reset is held low before reprogramming.
- CalibTimeout, 1048576, calibration watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  free-running sequencer clock (DRAM auxiliary clock).
- rst_i  in  1  synchronous, active-high reset.
- calib_done_i  in  1  DRAM controller calibration complete (already synchronous to clk_i).
- div_value_o  out  DivWidth  divider value presented to the clock divider.
- div_valid_o  out  1  divider update valid.
- div_ready_i  in  1  divider accepted the update.
- drain_req_o  out  1  request the DRAM path (CDC + cut) to stop accepting new transactions.
- drain_ack_i  in  1  DRAM path empty and quiescent.
- soc_rst_no  out  1  active-low reset to SoC and CDC source side.
- reconf_req_i  in  1  request a divider change.
- reconf_div_i  in  DivWidth  requested divider, sampled with reconf_req_i.
- reconf_ack_o  out  1  one-cycle pulse: reconfiguration finished, SoC running again.
- running_o  out  1  SoC out of reset at the current divider.
- error_o  out  1  sticky error (calibration timeout, or illegal divider).

Behaviour:
- Reset: all outputs take their reset values one cycle after rst_i is sampled high, whatever the state.
  - soc_rst_no=0, div_valid_o=0, div_value_o=DefaultDiv, drain_req_o=0, reconf_ack_o=0, running_o=0, error_o=0.
  - State goes to WAIT_CALIB.
- WAIT_CALIB: stay until calib_done_i=1, then go to PROG.
- PROG:
  - div_valid_o=1 with div_value_o stable until div_ready_i=1.
  - The handshake completes in the cycle where both valid and ready are high; next cycle valid=0 and the state goes to SETTLE.
  - Valid is never dropped before ready.
- SETTLE: counter runs from 0 to SettleCycles-1; at terminal count go to RUN.
- RUN:
  - soc_rst_no=1 and running_o=1, both registered, effective the cycle after entry.
  - If calib_done_i drops, go to HOLD without a drain, because DRAM is lost.
- Reconfiguration request (RUN only):
  - reconf_req_i=1 latches reconf_div_i into the pending register.
  - Divider value 0 or 1 is illegal: set error_o, ignore the request, stay in RUN.
  - A legal value moves the state to DRAIN.
- DRAIN: drain_req_o=1 until drain_ack_i=1, then go to HOLD.
- HOLD:
  - soc_rst_no=0, running_o=0, drain_req_o=0.
  - Counter runs HoldCycles cycles.
  - On expiry: go to PROG using the pending divider; for the calib-loss path, go to WAIT_CALIB instead.
- reconf_ack_o pulses for one cycle on the first RUN cycle after a reconfiguration only, not after bring-up.
- reconf_req_i outside RUN is ignored; no queueing.
- Simultaneous events in RUN: a calib_done_i drop has priority over reconf_req_i.
- Counters are sized $clog2 of their limit plus 1 and saturate; they never wrap.
- Reset mid-handshake: div_valid_o drops the next cycle. The divider must tolerate an abandoned valid.

Optional Feature:
- Macro FPGA_CLK_RST_SEQ_CALIB_TIMEOUT_EN.
- Defined:
  - WAIT_CALIB counts cycles; reaching CalibTimeout sets error_o and moves to a terminal ERROR state.
  - ERROR holds soc_rst_no=0, and only rst_i exits it.
- Undefined: no counter and no ERROR state; WAIT_CALIB waits indefinitely, and error_o is set only by an illegal divider.

Decomposition:
- Shared FPGA target package holds:
  - the state enum (WAIT_CALIB, PROG, SETTLE, RUN, DRAIN, HOLD, ERROR);
  - the default divider constant, used by both this block and the clock divider default.
- One sub-module, fpga_seq_cnt: loadable saturating down-counter with a done flag, shared by SETTLE, HOLD and the timeout.

Test Plan:
- Bring-up: rst_i for 3 cycles, calib_done_i rises at cycle 100, div_ready_i tied 1 -> div_valid_o high 1 cycle with value 4; soc_rst_no rises 64+1 cycles after the handshake; running_o=1; reconf_ack_o never pulses.
- Backpressure: div_ready_i held 0 for 10 cycles in PROG -> div_valid_o stays 1 and div_value_o stable all 10 cycles; SETTLE starts only after the ready cycle.
- Reconfiguration: in RUN, reconf_req_i with div 8; drain_ack_i after 5 cycles -> drain_req_o high 5 cycles, soc_rst_no low 16 cycles, handshake with value 8, SETTLE 64 cycles, single reconf_ack_o pulse, running_o=1.
- Illegal and simultaneous inputs:
  - reconf_div_i=1 -> error_o=1, soc_rst_no stays 1.
  - calib_done_i drop coincident with reconf_req_i -> HOLD without drain_req_o, then WAIT_CALIB.
- Timeout (macro defined, CalibTimeout=1000 for the test): calib_done_i never rises -> error_o=1 at cycle 1000, soc_rst_no stays 0; rst_i clears it.
- Reset mid-operation: assert rst_i during DRAIN and during PROG -> drain_req_o and div_valid_o are 0 the next cycle; the sequence restarts from WAIT_CALIB.
